// File: rtl/fadd_result_buffer.sv
// Result buffer behind a fixed-latency pipelined adder: tracks issues, captures sums, grants credit.
// Optional per-entry NaN/Inf flags on out_exc when FADD_BUF_EXC_EN is defined.
module fadd_result_buffer #(
    parameter int LATENCY = 6,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_ok,
    input  logic [31:0]              sum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef FADD_BUF_EXC_EN
    ,
    output logic [1:0]               out_exc
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0] dl_valid;
    logic [TAG_W-1:0]   dl_tag [LATENCY];
    logic [CW-1:0]      in_flight;

    logic [31:0]        mem_data [DEPTH];
    logic [TAG_W-1:0]   mem_tag  [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_next;
    logic [CW-1:0]      count_next;
    logic               accept;
    logic               push;
    logic               pop;
    logic               head_is_push;

    assign issue_ok   = ({1'b0, in_flight} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign accept     = issue_valid & issue_ok;
    assign push       = dl_valid[LATENCY-1];
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign rd_next    = rd_ptr + AW'(pop);
    assign count_next = count + CW'(push) - CW'(pop);
    // Only when the FIFO drains to empty this edge can the new head be the entry being written.
    assign head_is_push = push && (wr_ptr == rd_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= accept;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dl_tag[0] <= issue_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else if (accept && !push) begin
            in_flight <= in_flight + 1'b1;
        end else if (!accept && push) begin
            in_flight <= in_flight - 1'b1;
        end
    end

`ifdef FADD_BUF_EXC_EN
    logic [1:0] exc_in;
    logic [1:0] mem_exc [DEPTH];

    always_comb begin
        exc_in = 2'b00;
        if (sum_in[30:23] == 8'hff) begin
            exc_in = (sum_in[22:0] != '0) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_exc[wr_ptr] <= exc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_exc <= '0;
        end else if (count_next != '0) begin
            out_exc <= head_is_push ? exc_in : mem_exc[rd_next];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sum_in;
            mem_tag[wr_ptr]  <= dl_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            out_tag  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // Head register reloads every edge while non-empty; holds its last value when empty.
            if (count_next != '0) begin
                if (head_is_push) begin
                    out_data <= sum_in;
                    out_tag  <= dl_tag[LATENCY-1];
                end else begin
                    out_data <= mem_data[rd_next];
                    out_tag  <= mem_tag[rd_next];
                end
            end
            if (issue_valid && !issue_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fadd_result_buffer.sv
// Randomized self-checking bench for fadd_result_buffer; the adder is modelled as a fixed delay of known sums.
module tb_fadd_result_buffer;
    localparam int LAT = 6;
    localparam int DEP = 8;
    localparam int TW  = 8;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic [TW-1:0] issue_tag;
    logic          issue_ok;
    logic [31:0]   sum_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;
    logic [3:0]    count;
    logic          overflow;
`ifdef FADD_BUF_EXC_EN
    logic [1:0]    out_exc;
`endif

    fadd_result_buffer #(
        .LATENCY(LAT),
        .DEPTH  (DEP),
        .TAG_W  (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_tag  (issue_tag),
        .issue_ok   (issue_ok),
        .sum_in     (sum_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .count      (count),
        .overflow   (overflow)
`ifdef FADD_BUF_EXC_EN
        ,
        .out_exc    (out_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int accepted = 0;
    int pops     = 0;
    bit issued   = 0;

    // Adder model: sum presented on Y at cycle (issue + LAT); reference model state below.
    logic [31:0] adder_out [int];
    int          infl_due [$];
    logic [31:0] infl_d   [$];
    logic [7:0]  infl_t   [$];
    logic [31:0] fifo_d   [$];
    logic [7:0]  fifo_t   [$];
    logic [31:0] last_d = '0;
    logic [7:0]  last_t = '0;
    bit          m_ovf  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expected);
        n_tests++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, expected);
        end
    endtask

`ifdef FADD_BUF_EXC_EN
    function automatic logic [1:0] exc_of(input logic [31:0] v);
        if (v[30:23] != 8'hff) return 2'b00;
        return (v[22:0] != '0) ? 2'b10 : 2'b01;
    endfunction
`endif

    // mode: 0 idle, 1 force issue, 2 issue only if the DUT grants credit
    task automatic step(input int mode, input logic [7:0] tg, input logic [31:0] d,
                        input bit rdy, input bit do_rst);
        bit          iv;
        bit          exp_ok;
        bit          pop;
        bit          cap;
        logic [31:0] e_d;
        logic [7:0]  e_t;
        @(negedge clk);
        exp_ok = (infl_due.size() + fifo_d.size()) < DEP;
        e_d = (fifo_d.size() > 0) ? fifo_d[0] : last_d;
        e_t = (fifo_t.size() > 0) ? fifo_t[0] : last_t;
        check("issue_ok", issue_ok, exp_ok);
        check("out_valid", out_valid, fifo_d.size() != 0);
        check("count", count, fifo_d.size());
        check("overflow", overflow, m_ovf);
        check("out_data", out_data, e_d);
        check("out_tag", out_tag, e_t);
`ifdef FADD_BUF_EXC_EN
        check("out_exc", out_exc, exc_of(e_d));
`endif
        iv = (mode == 1) || (mode == 2 && issue_ok);
        issued = iv;
        if (out_valid && rdy && !do_rst) pops++;
        if (iv && issue_ok && !do_rst) accepted++;

        rst         = do_rst;
        issue_valid = iv;
        issue_tag   = tg;
        out_ready   = rdy;
        if (adder_out.exists(cyc)) begin
            sum_in = adder_out[cyc];
            adder_out.delete(cyc);
        end else begin
            sum_in = $urandom();
        end
        if (iv) adder_out[cyc + LAT] = d;

        if (do_rst) begin
            infl_due.delete(); infl_d.delete(); infl_t.delete();
            fifo_d.delete(); fifo_t.delete();
            last_d = '0; last_t = '0; m_ovf = 0;
        end else begin
            pop = (fifo_d.size() > 0) && rdy;
            cap = (infl_due.size() > 0) && (infl_due[0] == cyc);
            if (iv && !exp_ok) m_ovf = 1;
            if (pop) begin
                last_d = fifo_d.pop_front();
                last_t = fifo_t.pop_front();
            end
            if (cap) begin
                void'(infl_due.pop_front());
                fifo_d.push_back(infl_d.pop_front());
                fifo_t.push_back(infl_t.pop_front());
            end
            if (iv && exp_ok) begin
                infl_due.push_back(cyc + LAT);
                infl_d.push_back(d);
                infl_t.push_back(tg);
            end
        end
        cyc++;
    endtask

    initial begin
        int tag_i;
        int pops_before;
        rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; out_ready = 1'b0; sum_in = '0;
        repeat (2) @(posedge clk);

        // reset state, then single op 25.0 + 2.0 = 27.0
        step(0, 8'h00, 32'h0, 1, 0);
        pops_before = pops;
        step(1, 8'h11, 32'h41d80000, 1, 0);
        repeat (LAT + 4) step(0, 8'h00, 32'h0, 1, 0);
        check("single_pops", pops - pops_before, 1);
        // +Inf + 1.0 = +Inf
        step(1, 8'h12, 32'h7f800000, 1, 0);
        repeat (LAT + 4) step(0, 8'h00, 32'h0, 1, 0);

        // credit exhaustion
        accepted = 0;
        repeat (20) step(2, 8'($urandom()), $urandom(), 0, 0);
        check("credit_accepted", accepted, DEP);
        check("credit_count", count, DEP);
        check("credit_ovf", overflow, 0);

        // drain with wrap, tags 0x00..0x17
        pops = 0;
        tag_i = 0;
        for (int k = 0; k < 400 && (tag_i < 24 || count != 0 || infl_due.size() > 0); k++) begin
            step((tag_i < 24) ? 2 : 0, 8'(tag_i), $urandom(), k[0], 0);
            if (issued) tag_i++;
        end
        check("drain_done", (tag_i == 24) && (count == 0), 1);
        check("drain_pops", pops, 32);

        // steady simultaneous push/pop
        for (int k = 0; k < 30; k++) begin
            step(1, 8'(8'h80 + k), $urandom(), 1, 0);
            if (k > LAT + 1) check("steady_count", count, 1);
        end
        repeat (LAT + 3) step(0, 8'h00, 32'h0, 1, 0);

        // overflow: fill, force issues without credit
        repeat (12) step(2, 8'($urandom()), $urandom(), 0, 0);
        repeat (3) step(1, 8'hee, $urandom(), 0, 0);
        repeat (LAT + 3) step(0, 8'h00, 32'h0, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, DEP);
        repeat (12) step(0, 8'h00, 32'h0, 1, 0);
        check("ovf_sticky", overflow, 1);

        // reset mid-flight
        pops_before = pops;
        for (int k = 0; k < 3; k++) step(1, 8'(8'h50 + k), $urandom(), 1, 0);
        repeat (2) step(0, 8'h00, 32'h0, 1, 0);
        step(0, 8'h00, 32'h0, 1, 1);
        repeat (LAT + 4) step(0, 8'h00, 32'h0, 1, 0);
        check("rst_no_out", pops - pops_before, 0);
        check("rst_issue_ok", issue_ok, 1);

        // random mix
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 7) == 0) ? 1 : 2, 8'($urandom()), $urandom(),
                 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
        end
        repeat (LAT + 10) step(0, 8'h00, 32'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fadd_result_buffer.md
Name: fadd_result_buffer

Overview:
- Downstream companion to the fixed-latency pipelined single-precision adder (ports clk, A, B, Y; no handshake).
- Tracks which adder issue slots carry real operations with a valid/tag delay line matched to the adder latency.
- Captures each valid sum from the adder's Y into a FIFO and presents it on a valid/ready interface.
- Grants issue credit upstream, so results never overflow the FIFO even though the adder cannot stall.

Parameters:
- LATENCY, 6: clock cycles from A/B applied at the adder to the matching Y; must be >= 1.
- DEPTH, 8: FIFO entries, power of two, >= 2.
- TAG_W, 8: width of the user tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock, shared with the adder.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  an operand pair is driven onto the adder's A/B this cycle.
- issue_tag  input  TAG_W  tag for that operation.
- issue_ok  output  1  credit available; upstream may assert issue_valid this cycle only if high.
- sum_in  input  32  adder Y.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  32  head sum.
- out_tag  output  TAG_W  head tag.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; an issue arrived without credit.

Behaviour:
- Reset (rst high at a clock edge):
  - Delay line is cleared and in_flight = 0.
  - FIFO is emptied: count = 0, out_valid = 0, out_data = 0, out_tag = 0, overflow = 0, issue_ok = 1.
  - Any operation in flight when reset occurs is discarded, and its sum is never captured.
- Delay line:
  - LATENCY stages of {valid, tag}; stage 0 loads {issue_valid & issue_ok, issue_tag} each cycle.
  - The stage LATENCY-1 output is aligned with sum_in; when its valid bit is 1, {sum_in, tag} is written to the FIFO that edge.
- in_flight: the number of valid bits in the delay line.
  - +1 on an accepted issue, -1 on a capture; both in the same cycle leave it unchanged.
- issue_ok is combinational: (in_flight + count) < DEPTH.
  - A pop in the current cycle does not add credit until the next cycle (conservative, no comb path from out_ready).
- Issue without credit (issue_valid = 1, issue_ok = 0):
  - The operation is not tracked and its result is dropped.
  - overflow is set and stays set until rst.
- FIFO: circular buffer; write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, and both pointers advance.
  - Push into an empty FIFO: out_valid rises the next cycle (registered head, no fall-through); minimum issue-to-out_valid latency is LATENCY+1 cycles.
  - Pop when empty cannot occur because out_valid = 0.
  - Full with no credit: a push is impossible by construction.
- Outputs:
  - out_data and out_tag hold the head entry stable while out_valid & !out_ready.
  - When the FIFO is empty they hold their last value.
- The data is passed through bit-exact; no arithmetic is performed on the sum.

Optional Feature:
- Macro: FADD_BUF_EXC_EN.
- Defined:
  - Adds an output out_exc [1:0], stored per entry.
  - Bit 1 is set for NaN: exponent 0xFF with a nonzero mantissa.
  - Bit 0 is set for Inf: exponent 0xFF with a zero mantissa.
  - out_exc resets to 0 and follows the same head-hold rules as out_data.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Single op:
  - Stimulus: issue A = 0x41c80000 (25.0) and B = 0x40000000 (2.0) with tag 0x11, out_ready = 1.
  - Response: out_valid for exactly 1 cycle at issue + LATENCY + 1, with out_data = 0x41d80000 (27.0), out_tag = 0x11, and count back to 0.
- Credit exhaustion:
  - Stimulus: out_ready = 0, issue every cycle while issue_ok is high.
  - Response: exactly DEPTH (8) issues are accepted and issue_ok falls after the 8th; count reaches 8, and overflow stays 0.
- Drain with wrap:
  - Stimulus: from full, toggle out_ready 1/0 while issuing tags 0x00..0x17.
  - Response: all 24 results emerge in order, with pointers wrapping; there are no duplicates or losses.
- Simultaneous push/pop:
  - Stimulus: out_ready = 1 with back-to-back issues.
  - Response: in steady state count holds at 1 and one result per cycle emerges.
- Overflow:
  - Stimulus: force issue_valid while issue_ok = 0.
  - Response: overflow = 1 and the sticky flag persists.
  - The FIFO contents and count are unchanged, and no extra output appears.
- Reset mid-flight:
  - Stimulus: issue 3 ops, then assert rst 2 cycles later.
  - Response: count = 0, out_valid = 0, and issue_ok = 1.
  - None of the 3 results ever appears.
  - With FADD_BUF_EXC_EN defined, an input of 0x7f800000 plus 0x3f800000 yields out_exc = 01.
